// File: rtl/sprite_anim_renderer.sv
// Sprite renderer: places one palettized, animated sprite with power-of-two scaling and
// mirroring. Three-stage pipeline in front of an external synchronous ROM.
module sprite_anim_renderer #(
    parameter int SPRITE_W   = 50,
    parameter int SPRITE_H   = 64,
    parameter int FRAMES     = 4,
    parameter int IDX_W      = 3,
    parameter int TRANSP_IDX = 0,
    parameter int MAX_SCALE  = 2,
    parameter int FRAME_DIV  = 8,
    parameter int ADDR_W     = $clog2(SPRITE_W * SPRITE_H * FRAMES),
    parameter int FRAME_W    = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               blank,
    input  logic               frame_tick,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic [1:0]         scale,
    input  logic               mirror,
    input  logic               anim_en,
    input  logic               anim_restart,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [IDX_W-1:0]   rom_q,
    output logic [IDX_W-1:0]   pix_idx,
    output logic               pix_hit,
    output logic               blank_out,
    output logic [FRAME_W-1:0] cur_frame
);

    localparam int DIV_W      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int FRAME_SIZE = SPRITE_W * SPRITE_H;
    localparam logic [1:0] SCALE_LIMIT = 2'(MAX_SCALE);

    // Shadow copies of the placement controls, updated only on frame_tick
    logic [9:0] sh_px;
    logic [9:0] sh_py;
    logic [1:0] sh_scale;
    logic       sh_mirror;

    logic [FRAME_W-1:0] frame_q;
    logic [DIV_W-1:0]   div_q;

    logic               hit1, blank1;
    logic               hit_d, blank_d;
    logic               hit2, blank2;
    logic [IDX_W-1:0]   idx2;

    logic [10:0]        box_w, box_h, x_end, y_end;
    logic [10:0]        dx, dy, lx_raw, lx, ly;
    logic               in_box;
    logic [ADDR_W-1:0]  next_addr;

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            sh_px     <= '0;
            sh_py     <= '0;
            sh_scale  <= '0;
            sh_mirror <= 1'b0;
        end else if (frame_tick) begin
            sh_px     <= pos_x;
            sh_py     <= pos_y;
            sh_scale  <= (scale > SCALE_LIMIT) ? SCALE_LIMIT : scale;
            sh_mirror <= mirror;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            frame_q <= '0;
            div_q   <= '0;
        end else if (frame_tick) begin
            if (anim_restart) begin
                frame_q <= '0;
                div_q   <= '0;
            end else if (anim_en) begin
                if (div_q == DIV_W'(FRAME_DIV - 1)) begin
                    div_q   <= '0;
                    frame_q <= (frame_q == FRAME_W'(FRAMES - 1)) ? '0 : frame_q + 1'b1;
                end else begin
                    div_q <= div_q + 1'b1;
                end
            end
        end
    end

    assign cur_frame = frame_q;

    // Box test in 11 bits so a sprite hanging past x/y=1023 clips instead of wrapping
    always_comb begin
        box_w  = 11'(SPRITE_W) << sh_scale;
        box_h  = 11'(SPRITE_H) << sh_scale;
        x_end  = {1'b0, sh_px} + box_w;
        y_end  = {1'b0, sh_py} + box_h;
        in_box = ({1'b0, DrawX} >= {1'b0, sh_px}) && ({1'b0, DrawX} < x_end) &&
                 ({1'b0, DrawY} >= {1'b0, sh_py}) && ({1'b0, DrawY} < y_end);
        dx     = {1'b0, DrawX} - {1'b0, sh_px};
        dy     = {1'b0, DrawY} - {1'b0, sh_py};
        lx_raw = dx >> sh_scale;
        ly     = dy >> sh_scale;
        lx     = sh_mirror ? (11'(SPRITE_W - 1) - lx_raw) : lx_raw;
        next_addr = '0;
        if (in_box) begin
            next_addr = ADDR_W'(frame_q) * ADDR_W'(FRAME_SIZE)
                      + ADDR_W'(ly) * ADDR_W'(SPRITE_W)
                      + ADDR_W'(lx);
        end
    end

    // hit_d/blank_d cover the ROM's one-cycle read so flags meet rom_q in stage 2
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            rom_addr  <= '0;
            hit1      <= 1'b0;
            blank1    <= 1'b0;
            hit_d     <= 1'b0;
            blank_d   <= 1'b0;
            hit2      <= 1'b0;
            blank2    <= 1'b0;
            idx2      <= '0;
            pix_idx   <= '0;
            pix_hit   <= 1'b0;
            blank_out <= 1'b0;
        end else begin
            rom_addr  <= next_addr;
            hit1      <= in_box;
            blank1    <= blank;
            hit_d     <= hit1;
            blank_d   <= blank1;
            hit2      <= hit_d;
            blank2    <= blank_d;
            idx2      <= rom_q;
            pix_idx   <= idx2;
            pix_hit   <= hit2 && blank2 && (idx2 != IDX_W'(TRANSP_IDX));
            blank_out <= blank2;
        end
    end

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Directed bench for sprite_anim_renderer: behavioural ROM, reference model and a
// scoreboard queue that lines pushed expectations up with the 3-cycle pixel latency.
module tb_sprite_anim_renderer;

    localparam int W  = 50;
    localparam int H  = 64;
    localparam int AW = 14;
    localparam int ROM_DEPTH = W * H * 4;

    logic          vga_clk = 1'b0;
    logic          reset_n;
    logic [9:0]    DrawX, DrawY, pos_x, pos_y;
    logic          blank, frame_tick, mirror, anim_en, anim_restart;
    logic [1:0]    scale;
    logic [AW-1:0] rom_addr;
    logic [2:0]    rom_q;
    logic [2:0]    pix_idx;
    logic          pix_hit, blank_out;
    logic [1:0]    cur_frame;

    logic [2:0]    rom [0:ROM_DEPTH-1];

    always #5 vga_clk = ~vga_clk;

    always_ff @(posedge vga_clk) rom_q <= rom[rom_addr];

    sprite_anim_renderer #(
        .SPRITE_W(W), .SPRITE_H(H), .FRAMES(4), .IDX_W(3), .TRANSP_IDX(0),
        .MAX_SCALE(2), .FRAME_DIV(8)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y),
        .scale(scale), .mirror(mirror), .anim_en(anim_en), .anim_restart(anim_restart),
        .rom_addr(rom_addr), .rom_q(rom_q), .pix_idx(pix_idx), .pix_hit(pix_hit),
        .blank_out(blank_out), .cur_frame(cur_frame)
    );

    typedef struct {
        bit       hit;
        bit [2:0] idx;
        bit       blk;
        bit       chk_idx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int   m_px, m_py, m_s, m_frame, m_div;
    bit   m_mirror;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    function automatic int model_addr(input int x, input int y);
        int w, h, lx, ly;
        w = W << m_s;
        h = H << m_s;
        if (x < m_px || x >= m_px + w || y < m_py || y >= m_py + h) return -1;
        lx = (x - m_px) >> m_s;
        ly = (y - m_py) >> m_s;
        if (m_mirror) lx = W - 1 - lx;
        return m_frame * W * H + ly * W + lx;
    endfunction

    task automatic step(input int x, input int y, input bit b, input bit tick);
        int   a;
        exp_t e;
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        frame_tick = tick;
        a = model_addr(x, y);
        e.idx = rom[(a >= 0) ? a : 0];
        e.hit = (a >= 0) && b && (e.idx != 3'd0);
        e.blk = b;
        e.chk_idx = 1'b1;
        sb.push_back(e);
        @(posedge vga_clk);
        #1;
        if (tick) begin
            m_px = pos_x;
            m_py = pos_y;
            m_s = (scale > 2) ? 2 : int'(scale);
            m_mirror = mirror;
            if (anim_restart) begin
                m_frame = 0;
                m_div = 0;
            end else if (anim_en) begin
                if (m_div == 7) begin
                    m_div = 0;
                    m_frame = (m_frame == 3) ? 0 : m_frame + 1;
                end else begin
                    m_div++;
                end
            end
        end
        frame_tick = 1'b0;
        chk("rom_addr", rom_addr, (a >= 0) ? a : 0);
        chk("cur_frame", cur_frame, m_frame);
        if (sb.size() == 4) begin
            e = sb.pop_front();
            chk("pix_hit", pix_hit, e.hit);
            chk("blank_out", blank_out, e.blk);
            if (e.chk_idx) chk("pix_idx", pix_idx, e.idx);
        end
    endtask

    task automatic reset_steps(input int n);
        exp_t z;
        for (int i = 0; i < n; i++) begin
            reset_n = 1'b0;
            DrawX = 10'd10;
            DrawY = 10'd5;
            blank = 1'b1;
            frame_tick = 1'b0;
            @(posedge vga_clk);
            #1;
            chk("rst_rom_addr", rom_addr, 0);
            chk("rst_pix_hit", pix_hit, 0);
            chk("rst_blank_out", blank_out, 0);
            chk("rst_cur_frame", cur_frame, 0);
        end
        reset_n = 1'b1;
        sb.delete();
        m_px = 0; m_py = 0; m_s = 0; m_mirror = 1'b0; m_frame = 0; m_div = 0;
        z = '{hit: 1'b0, idx: 3'd0, blk: 1'b0, chk_idx: 1'b0};
        for (int i = 0; i < 3; i++) sb.push_back(z);
    endtask

    task automatic cfg(input int px, input int py, input int s, input bit m);
        pos_x = 10'(px);
        pos_y = 10'(py);
        scale = 2'(s);
        mirror = m;
        step(700, 500, 1'b0, 1'b1);
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) step(700, 500, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        DrawX = '0; DrawY = '0; blank = 1'b0; frame_tick = 1'b0;
        pos_x = '0; pos_y = '0; scale = '0; mirror = 1'b0;
        anim_en = 1'b0; anim_restart = 1'b0;
        for (int i = 0; i < ROM_DEPTH; i++) rom[i] = 3'd5;

        // Power-up reset, then an in-box pixel straight away to see the 3-cycle latency
        reset_steps(3);
        for (int x = 0; x < 8; x++) step(x, 5, 1'b1, 1'b0);

        // Reset in the middle of a line discards in-flight pixels
        reset_steps(3);
        for (int x = 20; x < 26; x++) step(x, 5, 1'b1, 1'b0);

        // Placement at (100,50), scale 0
        cfg(100, 50, 0, 1'b0);
        for (int x = 95; x <= 155; x++) begin
            step(x, 50, 1'b1, 1'b0);
            if (x == 100) chk("place_addr_x100", rom_addr, 0);
            if (x == 149) chk("place_addr_x149", rom_addr, 49);
            if (x == 150) chk("place_addr_x150", rom_addr, 0);
        end
        step(120, 49, 1'b1, 1'b0);
        step(120, 113, 1'b1, 1'b0);
        step(120, 114, 1'b1, 1'b0);
        step(120, 60, 1'b0, 1'b0);
        flush();

        // Scale 1 with mirroring at the origin
        cfg(0, 0, 1, 1'b1);
        step(0, 0, 1'b1, 1'b0);   chk("mir_x0", rom_addr, 49);
        step(1, 0, 1'b1, 1'b0);   chk("mir_x1", rom_addr, 49);
        step(99, 0, 1'b1, 1'b0);  chk("mir_x99", rom_addr, 0);
        step(0, 127, 1'b1, 1'b0); chk("mir_y127", rom_addr, 63 * 50 + 49);
        step(100, 0, 1'b1, 1'b0); chk("mir_x100", rom_addr, 0);
        flush();

        // Transparency index
        rom[10] = 3'd0;
        rom[11] = 3'd3;
        cfg(0, 0, 0, 1'b0);
        step(10, 0, 1'b1, 1'b0);
        step(11, 0, 1'b1, 1'b0);
        step(700, 500, 1'b0, 1'b0);
        step(700, 500, 1'b0, 1'b0);
        chk("transp_hit_x10", pix_hit, 0);
        step(700, 500, 1'b0, 1'b0);
        chk("opaque_hit_x11", pix_hit, 1);
        chk("opaque_idx_x11", pix_idx, 3);

        // Animation: 32 ticks walk frames 0..3 and wrap
        rom[3200] = 3'd6;
        anim_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step(700, 500, 1'b0, 1'b1);
            chk("anim_frame", cur_frame, ((i + 1) / 8) % 4);
            if (i == 7) begin
                step(0, 0, 1'b1, 1'b0);
                chk("frame1_base", rom_addr, 3200);
            end
            step(700, 500, 1'b0, 1'b0);
        end
        for (int i = 0; i < 19; i++) step(700, 500, 1'b0, 1'b1);
        chk("frame2_reached", cur_frame, 2);
        anim_restart = 1'b1;
        step(700, 500, 1'b0, 1'b1);
        anim_restart = 1'b0;
        chk("restart_frame", cur_frame, 0);
        for (int i = 0; i < 7; i++) step(700, 500, 1'b0, 1'b1);
        chk("restart_div_cleared", cur_frame, 0);
        step(700, 500, 1'b0, 1'b1);
        chk("restart_div_step", cur_frame, 1);
        anim_en = 1'b0;
        step(700, 500, 1'b0, 1'b1);
        chk("anim_hold", cur_frame, 1);
        flush();

        // Shadow latch: pos_x change takes effect only at the next tick (frame 1 shown)
        cfg(100, 50, 0, 1'b0);
        pos_x = 10'd200;
        for (int x = 95; x <= 255; x++) begin
            step(x, 50, 1'b1, 1'b0);
            if (x == 120) chk("shadow_old_x120", rom_addr, 3220);
            if (x == 220) chk("shadow_old_x220", rom_addr, 0);
        end
        step(700, 500, 1'b0, 1'b1);
        for (int x = 95; x <= 255; x++) begin
            step(x, 50, 1'b1, 1'b0);
            if (x == 120) chk("shadow_new_x120", rom_addr, 0);
            if (x == 220) chk("shadow_new_x220", rom_addr, 3220);
        end

        // Out-of-range scale clamps to the maximum exponent
        cfg(0, 0, 3, 1'b0);
        step(199, 0, 1'b1, 1'b0); chk("clamp_in", rom_addr, 3249);
        step(200, 0, 1'b1, 1'b0); chk("clamp_out", rom_addr, 0);
        step(0, 255, 1'b1, 1'b0); chk("clamp_row63", rom_addr, 3200 + 63 * 50);

        // Reset mid-frame, then normal output resumes
        step(5, 5, 1'b1, 1'b0);
        reset_steps(3);
        for (int x = 0; x < 6; x++) step(x, 0, 1'b1, 1'b0);
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_anim_renderer.md
Name: sprite_anim_renderer

Overview:
- Parametrised sprite renderer that replaces the full-screen-stretch sprite example.
- Places one W x H palettized sprite at a programmable screen position, with power-of-two scaling, horizontal mirroring, a transparency index and multi-frame animation.
- Sits between the VGA controller (DrawX/DrawY/blank) and an external synchronous sprite ROM plus combinational palette. Emits a per-pixel hit flag and a palette index to the colour mux.

Parameters:
- SPRITE_W, 50, sprite width in pixels.
- SPRITE_H, 64, sprite height in pixels.
- FRAMES, 4, number of animation frames stored back-to-back in the ROM.
- IDX_W, 3, palette index width (ROM data width).
- TRANSP_IDX, 0, palette index treated as transparent.
- MAX_SCALE, 2, maximum scale exponent (scale factor 2^s, s in 0..MAX_SCALE).
- FRAME_DIV, 8, number of frame_tick pulses per animation step.
- ADDR_W, clog2(SPRITE_W*SPRITE_H*FRAMES), ROM address width.

Ports:
- vga_clk  in  1  pixel clock; all state on posedge.
- reset_n  in  1  synchronous active-low reset.
- DrawX  in  10  current pixel x.
- DrawY  in  10  current pixel y.
- blank  in  1  1 = active video.
- frame_tick  in  1  one-cycle pulse per video frame (vsync start).
- pos_x  in  10  requested sprite left edge (unsigned).
- pos_y  in  10  requested sprite top edge (unsigned).
- scale  in  2  requested scale exponent; values above MAX_SCALE clamp to MAX_SCALE.
- mirror  in  1  requested horizontal flip.
- anim_en  in  1  1 = animation advances.
- anim_restart  in  1  force frame 0 at the next frame_tick.
- rom_addr  out  ADDR_W  address to the external ROM (registered).
- rom_q  in  IDX_W  ROM data; valid one cycle after rom_addr.
- pix_idx  out  IDX_W  palette index for the current output pixel.
- pix_hit  out  1  1 = sprite covers the pixel and the pixel is opaque.
- blank_out  out  1  blank delayed to align with pix_idx/pix_hit.
- cur_frame  out  clog2(FRAMES)  currently displayed frame.

Behaviour:
- Reset (reset_n=0 at a posedge): all of the following clear to 0 — the shadow registers (pos, scale, mirror), the frame counter, the divider counter, all pipeline registers, rom_addr, pix_idx, pix_hit, blank_out and cur_frame.
  - Reset mid-line or mid-frame discards all in-flight pipeline data.
- Shadow latch: pos_x, pos_y, scale (clamped) and mirror are captured only on a cycle with frame_tick=1. Changes at any other time have no effect until the next tick, so there is no tearing.
- Animation, evaluated on frame_tick cycles only. Priority: anim_restart, then anim_en.
  - anim_restart=1: frame=0, div=0.
  - Else if anim_en=1: if div==FRAME_DIV-1, then div=0 and frame=(frame==FRAMES-1)?0:frame+1; else div=div+1.
  - anim_en=0: frame and div hold.
  - cur_frame reflects the frame register.
- Stage 1 (posedge N, inputs sampled at N):
  - Compute in-box in 11-bit arithmetic: in_box = (DrawX>=px) && (DrawX<px+(SPRITE_W<<s)) && (DrawY>=py) && (DrawY<py+(SPRITE_H<<s)). A box extending past 1023 is clipped naturally.
  - lx=(DrawX-px)>>s and ly=(DrawY-py)>>s.
  - If mirror, lx=SPRITE_W-1-lx.
  - rom_addr <= frame*SPRITE_W*SPRITE_H + ly*SPRITE_W + lx when in_box, else 0.
  - Register hit1=in_box, blank1=blank.
- Stage 2: the ROM returns rom_q at N+1. Register hit2, blank2 and idx2=rom_q.
- Stage 3:
  - pix_idx <= idx2.
  - pix_hit <= hit2 && blank2 && (idx2!=TRANSP_IDX).
  - blank_out <= blank2.
- Latency: DrawX/DrawY/blank sampled at edge N, then pix_idx/pix_hit/blank_out valid after edge N+3. Fully pipelined at one pixel per clock.
- Outside the box, pix_hit=0 and pix_idx is don't-care but driven from rom_q of address 0.
- Multiplications use constant parameters only, so they synthesise to shifts and adds.
- The frame used for addressing is the value held in the register; a frame_tick coinciding with a pixel changes the address from the next cycle on.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles mid-line -> rom_addr=0, pix_hit=0, blank_out=0, cur_frame=0. After release, the first valid pix_hit appears no earlier than 3 cycles after the first in-box pixel.
- Placement/latency: pos=(100,50), scale=0, frame 0, ROM all index 5. Sweep DrawX with DrawY=50 -> pix_hit=1 exactly for DrawX 100..149, delayed 3 cycles; rom_addr=DrawX-100 at DrawX 100..149.
- Scale/mirror: scale=1, mirror=1, pos=(0,0). DrawX=0,DrawY=0 -> rom_addr=49. DrawX=1 -> 49. DrawX=99 -> 0. DrawY=127 -> row 63 (addr 63*50+49 at X=0). DrawX=100 -> pix_hit=0.
- Transparency: ROM address 10 holds TRANSP_IDX=0, address 11 holds 3. At scale 0, pos 0, DrawY 0: DrawX=10 -> pix_hit=0; DrawX=11 -> pix_hit=1, pix_idx=3.
- Animation wrap/restart: anim_en=1, FRAME_DIV=8, pulse frame_tick 32 times -> cur_frame steps 0,1,2,3 every 8 ticks, then back to 0. Tick with anim_restart=1 while frame=2 -> frame=0, div=0. The frame-1 base address is 3200.
- Shadow latch: change pos_x from 100 to 200 mid-frame -> the hit region stays at 100..149 until the next frame_tick, then moves to 200..249.
